// File: rtl/pinball_pkg.sv
// Shared pinball definitions: screen geometry defaults and the target FSM encoding,
// used by the target spawner, the VGA draw block and the collision block.
package pinball_pkg;

   localparam int unsigned PB_X_MIN   = 10;
   localparam int unsigned PB_X_MAX   = 380;
   localparam int unsigned PB_Y_START = 20;
   localparam int unsigned PB_Y_LIMIT = 460;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SPAWN  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_GAP    = 2'd3
   } spawn_state_t;

endpackage

// File: rtl/target_spawner.sv
// Target lifecycle for the pinball playfield: spawn at a clamped random x, fall one
// pixel per frame, score on hit, expire at the bottom, then wait a gap before respawning.
module target_spawner
   import pinball_pkg::*;
#(
   parameter int unsigned X_MIN          = PB_X_MIN,
   parameter int unsigned X_MAX          = PB_X_MAX,
   parameter int unsigned Y_START        = PB_Y_START,
   parameter int unsigned Y_LIMIT        = PB_Y_LIMIT,
   parameter int unsigned RESPAWN_FRAMES = 30
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         frame_tick,
   input  logic [8:0]   rand_in,
   input  logic         hit,
   output logic [8:0]   target_x,
   output logic [8:0]   target_y,
   output logic         target_active,
   output logic         score_pulse,
   output spawn_state_t o_state
);

   localparam logic [8:0] X_MIN9   = 9'(X_MIN);
   localparam logic [8:0] X_MAX9   = 9'(X_MAX);
   localparam logic [8:0] Y_START9 = 9'(Y_START);
   localparam logic [8:0] Y_LIMIT9 = 9'(Y_LIMIT);
   localparam int         CW       = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(RESPAWN_FRAMES);

   spawn_state_t  r_state;
   logic [8:0]    r_target_x;
   logic [8:0]    r_target_y;
   logic          r_target_active;
   logic          r_score_pulse;
   logic [CW-1:0] r_count;
   logic [8:0]    w_x_spawn;

   always_comb begin
      w_x_spawn = rand_in;
      if (rand_in < X_MIN9) begin
         w_x_spawn = X_MIN9;
      end else if (rand_in > X_MAX9) begin
         w_x_spawn = X_MAX9;
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_target_x      <= X_MIN9;
         r_target_y      <= Y_START9;
         r_target_active <= 1'b0;
         r_score_pulse   <= 1'b0;
         r_count         <= '0;
      end else begin
         // score_pulse is high only in the cycle right after the ACTIVE->GAP hit transition
         r_score_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (frame_tick) begin
                  r_state <= ST_SPAWN;
               end
            end
            ST_SPAWN: begin
               r_target_x      <= w_x_spawn;
               r_target_y      <= Y_START9;
               r_target_active <= 1'b1;
               r_state         <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               // A hit outranks expiry and movement when they coincide.
               if (hit) begin
                  r_score_pulse   <= 1'b1;
                  r_target_active <= 1'b0;
                  r_count         <= CNT_LOAD;
                  r_state         <= ST_GAP;
               end else if (frame_tick) begin
                  if (r_target_y == Y_LIMIT9) begin
                     r_target_active <= 1'b0;
                     r_count         <= CNT_LOAD;
                     r_state         <= ST_GAP;
                  end else begin
                     r_target_y <= r_target_y + 9'd1;
                  end
               end
            end
            ST_GAP: begin
               // An exhausted counter (including a zero-length gap) respawns on the next cycle.
               if (r_count == '0) begin
                  r_state <= ST_SPAWN;
               end else if (frame_tick) begin
                  r_count <= r_count - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign target_x      = r_target_x;
   assign target_y      = r_target_y;
   assign target_active = r_target_active;
   assign score_pulse   = r_score_pulse;
   assign o_state       = r_state;

endmodule

// File: tb/tb_target_spawner.sv
// Directed bench for target_spawner: clamp, movement, hit/expiry priority, gap timing, reset abort.
module tb_target_spawner;
   import pinball_pkg::*;

   logic         CLK;
   logic         reset;
   logic         frame_tick;
   logic [8:0]   rand_in;
   logic         hit;
   logic [8:0]   target_x;
   logic [8:0]   target_y;
   logic         target_active;
   logic         score_pulse;
   spawn_state_t o_state;

   int n_checks = 0;
   int n_pass   = 0;
   int n_pulses = 0;
   logic prev_pulse   = 1'b0;
   logic double_pulse = 1'b0;

   target_spawner dut (
      .CLK           (CLK),
      .reset         (reset),
      .frame_tick    (frame_tick),
      .rand_in       (rand_in),
      .hit           (hit),
      .target_x      (target_x),
      .target_y      (target_y),
      .target_active (target_active),
      .score_pulse   (score_pulse),
      .o_state       (o_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Independent pulse monitor: counts pulses and flags back-to-back assertion.
   always @(posedge CLK) begin
      if (score_pulse && prev_pulse) double_pulse = 1'b1;
      if (score_pulse) n_pulses = n_pulses + 1;
      prev_pulse = score_pulse;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One frame: a single-cycle frame_tick followed by a quiet cycle.
   task automatic frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   task automatic check_outputs(input string tag, input logic [8:0] ex, input logic [8:0] ey,
                                input logic ea, input logic ep, input spawn_state_t es);
      check({tag, ".x"},      32'(target_x),      32'(ex));
      check({tag, ".y"},      32'(target_y),      32'(ey));
      check({tag, ".active"}, 32'(target_active), 32'(ea));
      check({tag, ".pulse"},  32'(score_pulse),   32'(ep));
      check({tag, ".state"},  32'(o_state),       32'(es));
   endtask

   initial begin
      reset      = 1'b0;
      frame_tick = 1'b0;
      rand_in    = 9'd0;
      hit        = 1'b0;
      repeat (3) step();
      check_outputs("reset", 9'd10, 9'd20, 1'b0, 1'b0, ST_IDLE);

      reset = 1'b1;
      step();
      check("idle_wait", 32'(o_state), 32'(ST_IDLE));

      // Clamp low
      rand_in    = 9'd5;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_outputs("spawn_cycle", 9'd10, 9'd20, 1'b0, 1'b0, ST_SPAWN);
      step();
      check_outputs("clamp_low", 9'd10, 9'd20, 1'b1, 1'b0, ST_ACTIVE);

      repeat (3) frame();
      check("fall3.y", 32'(target_y), 32'd23);

      // Hit in ACTIVE
      hit = 1'b1;
      step();
      hit = 1'b0;
      check_outputs("hit", 9'd10, 9'd23, 1'b0, 1'b1, ST_GAP);
      step();
      check("hit_after.pulse", 32'(score_pulse), 32'd0);

      // Hit during GAP is ignored
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("gap_hit.pulse", 32'(score_pulse), 32'd0);

      // Respawn after 30 frames with clamp high
      rand_in = 9'd450;
      repeat (29) frame();
      check("gap29.state", 32'(o_state), 32'(ST_GAP));
      frame();
      check("gap30.state", 32'(o_state), 32'(ST_SPAWN));
      step();
      check_outputs("clamp_high", 9'd380, 9'd20, 1'b1, 1'b0, ST_ACTIVE);

      // Pass-through spawn
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("hit2.state", 32'(o_state), 32'(ST_GAP));
      rand_in = 9'd200;
      repeat (30) frame();
      step();
      check_outputs("pass", 9'd200, 9'd20, 1'b1, 1'b0, ST_ACTIVE);

      // Expiry without hit
      repeat (440) frame();
      check_outputs("at_limit", 9'd200, 9'd460, 1'b1, 1'b0, ST_ACTIVE);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check_outputs("expire", 9'd200, 9'd460, 1'b0, 1'b0, ST_GAP);
      step();
      check("expire_after.pulse", 32'(score_pulse), 32'd0);

      rand_in = 9'd300;
      repeat (30) frame();
      step();
      check_outputs("respawn300", 9'd300, 9'd20, 1'b1, 1'b0, ST_ACTIVE);

      // Hit coincident with expiring tick
      repeat (440) frame();
      frame_tick = 1'b1;
      hit        = 1'b1;
      step();
      frame_tick = 1'b0;
      hit        = 1'b0;
      check_outputs("simul", 9'd300, 9'd460, 1'b0, 1'b1, ST_GAP);
      step();
      check("simul_after.pulse", 32'(score_pulse), 32'd0);

      // Reset mid-ACTIVE, with a concurrent hit
      rand_in = 9'd120;
      repeat (30) frame();
      step();
      repeat (80) frame();
      check_outputs("y100", 9'd120, 9'd100, 1'b1, 1'b0, ST_ACTIVE);
      reset = 1'b0;
      hit   = 1'b1;
      step();
      hit = 1'b0;
      check_outputs("rst_active", 9'd10, 9'd20, 1'b0, 1'b0, ST_IDLE);

      // Reset mid-GAP
      reset   = 1'b1;
      rand_in = 9'd50;
      frame();
      check_outputs("spawn50", 9'd50, 9'd20, 1'b1, 1'b0, ST_ACTIVE);
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("hit3.pulse", 32'(score_pulse), 32'd1);
      reset = 1'b0;
      step();
      check_outputs("rst_gap", 9'd10, 9'd20, 1'b0, 1'b0, ST_IDLE);
      repeat (2) step();

      check("pulse_count", 32'(n_pulses), 32'd4);
      check("no_double_pulse", 32'(double_pulse), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
